// File: rtl/fifo_rd_packer_if.sv
// Bundle between the FIFO read packer, its upstream FIFO read port and the downstream beat sink.
// master = packer side, slave = upstream FIFO plus downstream consumer side.
interface fifo_rd_packer_if #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned RATIO = 4
);
    logic                     rempty;
    logic [DSIZE-1:0]         rdata;
    logic                     rreq;
    logic                     flush;
    logic [DSIZE*RATIO-1:0]   odata;
    logic [RATIO-1:0]         okeep;
    logic                     ovalid;
    logic                     oready;

    modport master (
        input  rempty, rdata, flush, oready,
        output rreq, odata, okeep, ovalid
    );

    modport slave (
        output rempty, rdata, flush, oready,
        input  rreq, odata, okeep, ovalid
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Pops DSIZE words from a first-word-fall-through FIFO and packs RATIO of them per output beat,
// with a flush path that emits a partially filled beat under a lane mask.
module fifo_rd_packer #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned RATIO = 4
) (
    input  logic             rclk,
    input  logic             rrst_n,
    fifo_rd_packer_if.master bus
);
    localparam int unsigned   CW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned   BW   = DSIZE * RATIO;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    // INIT0/INIT1 hold rreq low while the upstream empty flag settles after reset
    typedef enum logic [1:0] {
        ST_INIT0,
        ST_INIT1,
        ST_RUN,
        ST_FLUSH
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    acc_q, acc_d;
    logic [BW-1:0]    odata_q, odata_d;
    logic [RATIO-1:0] okeep_q, okeep_d;
    logic             ovalid_q, ovalid_d;

    logic             rreq_c;
    logic             pop_c;
    logic             free_c;
    logic [BW-1:0]    acc_w;
    logic [RATIO-1:0] mask_c;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state_q  <= ST_INIT0;
            cnt_q    <= '0;
            acc_q    <= '0;
            odata_q  <= '0;
            okeep_q  <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            odata_q  <= odata_d;
            okeep_q  <= okeep_d;
            ovalid_q <= ovalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        odata_d  = odata_q;
        okeep_d  = okeep_q;
        ovalid_d = ovalid_q && !bus.oready;
        free_c   = !ovalid_q || bus.oready;
        rreq_c   = 1'b0;
        pop_c    = 1'b0;
        acc_w    = acc_q;
        mask_c   = '0;

        // accumulator with the head word dropped into the current lane, and the partial-beat mask
        for (int unsigned k = 0; k < RATIO; k++) begin
            mask_c[k] = (k < 32'(cnt_q));
            if (CW'(k) == cnt_q) begin
                acc_w[k*DSIZE +: DSIZE] = bus.rdata;
            end
        end

        case (state_q)
            ST_INIT0: state_d = ST_INIT1;
            ST_INIT1: state_d = ST_RUN;
            ST_RUN: begin
                rreq_c = !((cnt_q == LAST) && !free_c);
                pop_c  = rreq_c && !bus.rempty;
                if (pop_c) begin
                    if (cnt_q == LAST) begin
                        cnt_d    = '0;
                        acc_d    = '0;
                        odata_d  = acc_w;
                        okeep_d  = '1;
                        ovalid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        acc_d = acc_w;
                    end
                end
                // flush only matters if words remain after this cycle's pop
                if (bus.flush && (cnt_d != '0)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (free_c) begin
                    odata_d  = acc_q;
                    okeep_d  = mask_c;
                    ovalid_d = 1'b1;
                    cnt_d    = '0;
                    acc_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_INIT0;
        endcase
    end

    assign bus.rreq   = rreq_c;
    assign bus.odata  = odata_q;
    assign bus.okeep  = okeep_q;
    assign bus.ovalid = ovalid_q;
endmodule
